// File: rtl/radiometer_pkg.sv
// Shared definitions for the radiometer back end command path:
// packet header default, FSM state encodings, register map and checksum helper.
package radiometer_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;

   localparam logic [7:0] ADDR_SW_PERIOD = 8'h01;
   localparam logic [7:0] ADDR_INT_LEN   = 8'h02;
   localparam logic [7:0] ADDR_UART_EN   = 8'h03;

   typedef enum logic [2:0] {
      PS_SYNC = 3'd0,
      PS_ADDR = 3'd1,
      PS_DHI  = 3'd2,
      PS_DLO  = 3'd3,
      PS_CHK  = 3'd4
   } parser_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   // Packet check byte: XOR of address and both data bytes.
   function automatic logic [7:0] cmd_checksum(input logic [7:0] addr,
                                               input logic [7:0] dhi,
                                               input logic [7:0] dlo);
      return addr ^ dhi ^ dlo;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser, start-edge detect, mid-bit sampling.
// byte_valid / frame_err are single-cycle registered pulses after the stop sample.
module uart_rx_byte
   import radiometer_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err,
   output logic       busy
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

   logic          sync1_q;
   logic          sync2_q;
   logic          prev_q;
   rx_state_e     state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic [7:0]    byte_data_q;
   logic          byte_valid_q;
   logic          frame_err_q;

   // Synchronise the idle-high line and keep one cycle of history for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Byte FSM: wait for a falling edge, confirm start mid-bit, shift LSB first, check stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RX_IDLE;
         cnt_q        <= {CW{1'b0}};
         bit_q        <= 3'd0;
         shift_q      <= 8'h00;
         byte_data_q  <= 8'h00;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               cnt_q <= {CW{1'b0}};
               bit_q <= 3'd0;
               if (prev_q && !sync2_q) begin
                  state_q <= RX_START;
               end
            end
            RX_START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q <= {CW{1'b0}};
                  // A line already back high is a glitch, not a start bit.
                  state_q <= sync2_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= {CW{1'b0}};
                  shift_q <= {sync2_q, shift_q[7:1]};
                  if (bit_q == 3'd7) begin
                     state_q <= RX_STOP;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_q == CNT_LAST) begin
                  // Leave straight after the sample so a back-to-back start edge is seen.
                  state_q <= RX_IDLE;
                  if (sync2_q) begin
                     byte_valid_q <= 1'b1;
                     byte_data_q  <= shift_q;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= RX_IDLE;
            end
         endcase
      end
   end

   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_data_q;
   assign frame_err  = frame_err_q;
   assign busy       = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: frames UART bytes into SYNC/ADDR/DHI/DLO/CHK packets,
// verifies the XOR checksum and issues a one-cycle configuration write.
module uart_cmd_rx
   import radiometer_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 868,
   parameter int         TIMEOUT_BITS = 20,
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rxd,
   output logic        cfg_wr,
   output logic [7:0]  cfg_addr,
   output logic [15:0] cfg_data,
   output logic        frame_err,
   output logic        chk_err,
   output logic        rx_busy
);

   localparam int            TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int            TW        = $clog2(TO_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES);

   logic          rx_valid_s;
   logic [7:0]    rx_data_s;
   logic          rx_frame_err_s;
   logic          rx_busy_s;

   parser_state_e state_q;
   logic [TW-1:0] to_cnt_q;
   logic [7:0]    addr_q;
   logic [7:0]    dhi_q;
   logic [7:0]    dlo_q;
   logic          cfg_wr_q;
   logic [7:0]    cfg_addr_q;
   logic [15:0]   cfg_data_q;
   logic          chk_err_q;
   logic          rx_busy_q;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rxd        (uart_rxd),
      .byte_valid (rx_valid_s),
      .byte_data  (rx_data_s),
      .frame_err  (rx_frame_err_s),
      .busy       (rx_busy_s)
   );

   // Packet parser with inter-byte timeout and registered write/error outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PS_SYNC;
         to_cnt_q   <= {TW{1'b0}};
         addr_q     <= 8'h00;
         dhi_q      <= 8'h00;
         dlo_q      <= 8'h00;
         cfg_wr_q   <= 1'b0;
         cfg_addr_q <= 8'h00;
         cfg_data_q <= 16'h0000;
         chk_err_q  <= 1'b0;
         rx_busy_q  <= 1'b0;
      end else begin
         cfg_wr_q  <= 1'b0;
         chk_err_q <= 1'b0;
         rx_busy_q <= rx_busy_s || (state_q != PS_SYNC);
         if (rx_frame_err_s) begin
            state_q  <= PS_SYNC;
            to_cnt_q <= {TW{1'b0}};
         end else if (rx_valid_s) begin
            to_cnt_q <= {TW{1'b0}};
            case (state_q)
               PS_SYNC: begin
                  state_q <= (rx_data_s == SYNC_BYTE) ? PS_ADDR : PS_SYNC;
               end
               PS_ADDR: begin
                  addr_q  <= rx_data_s;
                  state_q <= PS_DHI;
               end
               PS_DHI: begin
                  dhi_q   <= rx_data_s;
                  state_q <= PS_DLO;
               end
               PS_DLO: begin
                  dlo_q   <= rx_data_s;
                  state_q <= PS_CHK;
               end
               PS_CHK: begin
                  state_q <= PS_SYNC;
                  if (cmd_checksum(addr_q, dhi_q, dlo_q) == rx_data_s) begin
                     cfg_wr_q   <= 1'b1;
                     cfg_addr_q <= addr_q;
                     cfg_data_q <= {dhi_q, dlo_q};
                  end else begin
                     chk_err_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= PS_SYNC;
               end
            endcase
         end else if (state_q != PS_SYNC) begin
            // Silently abandon a partial packet once the host goes quiet too long.
            if (to_cnt_q == TO_LAST) begin
               state_q  <= PS_SYNC;
               to_cnt_q <= {TW{1'b0}};
            end else begin
               to_cnt_q <= to_cnt_q + 1'b1;
            end
         end else begin
            to_cnt_q <= {TW{1'b0}};
         end
      end
   end

   assign cfg_wr    = cfg_wr_q;
   assign cfg_addr  = cfg_addr_q;
   assign cfg_data  = cfg_data_q;
   assign frame_err = rx_frame_err_s;
   assign chk_err   = chk_err_q;
   assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 16 clocks per bit: a packet table plus
// hand-written timeout, glitch and mid-byte reset sequences.
module tb_uart_cmd_rx;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_rxd = 1'b1;
   logic        cfg_wr;
   logic [7:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic        frame_err;
   logic        chk_err;
   logic        rx_busy;

   uart_cmd_rx #(
      .CLKS_PER_BIT (CPB),
      .TIMEOUT_BITS (20),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .uart_rxd  (uart_rxd),
      .cfg_wr    (cfg_wr),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .frame_err (frame_err),
      .chk_err   (chk_err),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_wr  = 0;
   int n_chk = 0;
   int n_frm = 0;
   int n_bv  = 0;
   int n_multi = 0;
   int last_bv_cyc = 0;
   int last_wr_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (dut.u_rx.byte_valid) begin
         n_bv        <= n_bv + 1;
         last_bv_cyc <= cyc;
      end
      if (cfg_wr) begin
         n_wr        <= n_wr + 1;
         last_wr_cyc <= cyc;
      end
      if (chk_err)   n_chk <= n_chk + 1;
      if (frame_err) n_frm <= n_frm + 1;
      if (int'(cfg_wr) + int'(frame_err) + int'(chk_err) > 1) n_multi <= n_multi + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic v);
      uart_rxd = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      uart_rxd = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_ok);
   endtask

   typedef struct {
      logic [0:6][7:0] b;
      int              n;
      int              bad_idx;
      int              e_wr;
      int              e_chk;
      int              e_frm;
      logic [7:0]      e_addr;
      logic [15:0]     e_data;
   } vec_t;

   vec_t vt [7];

   initial begin
      int w0, c0, f0, b0;

      vt[0] = '{{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27, 8'h00, 8'h00}, 5, -1, 1, 0, 0, 8'h01, 16'h1234};
      vt[1] = '{{8'hA5, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00}, 5, -1, 0, 1, 0, 8'h01, 16'h1234};
      vt[2] = '{{8'hA5, 8'h02, 8'h00, 8'hFF, 8'hFD, 8'h00, 8'h00}, 5, -1, 1, 0, 0, 8'h02, 16'h00FF};
      vt[3] = '{{8'h00, 8'h5A, 8'hA5, 8'h03, 8'h00, 8'h01, 8'h02}, 7, -1, 1, 0, 0, 8'h03, 16'h0001};
      vt[4] = '{{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27, 8'h00, 8'h00}, 5,  2, 0, 0, 1, 8'h03, 16'h0001};
      vt[5] = '{{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00}, 5, -1, 1, 0, 0, 8'hA5, 16'hA5A5};
      vt[6] = '{{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64, 8'h00, 8'h00}, 5, -1, 1, 0, 0, 8'h02, 16'hABCD};

      // Reset state.
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset cfg_wr",    int'(cfg_wr),    0);
      check("reset cfg_addr",  int'(cfg_addr),  0);
      check("reset cfg_data",  int'(cfg_data),  0);
      check("reset frame_err", int'(frame_err), 0);
      check("reset chk_err",   int'(chk_err),   0);
      check("reset rx_busy",   int'(rx_busy),   0);
      idle_bits(2);

      // Packet table.
      for (int v = 0; v < 7; v++) begin
         w0 = n_wr; c0 = n_chk; f0 = n_frm;
         for (int i = 0; i < vt[v].n; i++) begin
            send_byte(vt[v].b[i], (i != vt[v].bad_idx));
            if (i == vt[v].bad_idx) idle_bits(2);
         end
         idle_bits(4);
         check($sformatf("vec%0d cfg_wr count", v),    n_wr - w0,  vt[v].e_wr);
         check($sformatf("vec%0d chk_err count", v),   n_chk - c0, vt[v].e_chk);
         check($sformatf("vec%0d frame_err count", v), n_frm - f0, vt[v].e_frm);
         check($sformatf("vec%0d cfg_addr", v),        int'(cfg_addr), int'(vt[v].e_addr));
         check($sformatf("vec%0d cfg_data", v),        int'(cfg_data), int'(vt[v].e_data));
         check($sformatf("vec%0d rx_busy idle", v),    int'(rx_busy), 0);
         if (vt[v].e_wr != 0)
            check($sformatf("vec%0d wr after byte_valid", v), last_wr_cyc - last_bv_cyc, 1);
      end

      // Timeout: 21 idle bit times after the address byte abandons the packet.
      w0 = n_wr; c0 = n_chk; f0 = n_frm;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      idle_bits(2);
      check("timeout busy during partial", int'(rx_busy), 1);
      idle_bits(19);
      check("timeout parser back in sync", int'(rx_busy), 0);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h27, 1'b1);
      idle_bits(4);
      check("timeout no cfg_wr",    n_wr - w0,  0);
      check("timeout no chk_err",   n_chk - c0, 0);
      check("timeout no frame_err", n_frm - f0, 0);
      check("timeout addr held",    int'(cfg_addr), 8'h02);
      check("timeout data held",    int'(cfg_data), 16'hABCD);

      // A short gap well inside the timeout keeps the packet alive.
      w0 = n_wr;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      idle_bits(5);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h27, 1'b1);
      idle_bits(4);
      check("gap cfg_wr count", n_wr - w0, 1);
      check("gap cfg_addr", int'(cfg_addr), 8'h01);
      check("gap cfg_data", int'(cfg_data), 16'h1234);

      // Start-bit glitch of 3 cycles.
      b0 = n_bv; c0 = n_chk; f0 = n_frm;
      uart_rxd = 1'b0;
      repeat (3) @(negedge clk);
      idle_bits(3);
      check("glitch no byte_valid", n_bv - b0,  0);
      check("glitch no frame_err",  n_frm - f0, 0);
      check("glitch no chk_err",    n_chk - c0, 0);
      check("glitch rx_busy",       int'(rx_busy), 0);

      // Reset in the middle of a DATA phase, after a sync byte.
      w0 = n_wr; c0 = n_chk; f0 = n_frm; b0 = n_bv;
      send_byte(8'hA5, 1'b1);
      b0 = n_bv;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst = 1'b1;
      uart_rxd = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst mid-data no byte_valid", n_bv - b0, 0);
      check("rst mid-data no cfg_wr",     n_wr - w0, 0);
      check("rst mid-data cfg_addr",      int'(cfg_addr), 0);
      check("rst mid-data cfg_data",      int'(cfg_data), 0);
      check("rst mid-data rx_busy",       int'(rx_busy), 0);
      idle_bits(2);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h07, 1'b1);
      send_byte(8'h04, 1'b1);
      idle_bits(4);
      check("post-rst cfg_wr count", n_wr - w0, 1);
      check("post-rst cfg_addr",     int'(cfg_addr), 8'h03);
      check("post-rst cfg_data",     int'(cfg_data), 16'h0007);
      check("post-rst no chk_err",   n_chk - c0, 0);
      check("post-rst no frame_err", n_frm - f0, 0);

      check("pulses mutually exclusive", n_multi, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Host-to-instrument command receiver for the radiometer back end, the counterpart of the existing UART telemetry transmitter. It deserialises 8N1 bytes from the host on `uart_rxd`, frames them into fixed 5-byte command packets, verifies a checksum, and emits a single-cycle configuration write (address + 16-bit data). Downstream blocks, such as the switching-period or integration-length registers, latch on that write. Runs entirely in the 100 MHz `clk` domain.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); minimum 8.
- `TIMEOUT_BITS`, 20: inter-byte timeout in bit periods; a partial packet is abandoned when it expires.
- `SYNC_BYTE`, 8'hA5: packet header value.

Ports:
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: reset; synchronous, active-high.
- `uart_rxd` in 1: asynchronous serial input, idle high.
- `cfg_wr` out 1: one-cycle pulse; a valid command was received.
- `cfg_addr` out 8: register address; valid while `cfg_wr` is high, held afterwards.
- `cfg_data` out 16: register data; valid while `cfg_wr` is high, held afterwards.
- `frame_err` out 1: one-cycle pulse; stop bit sampled low.
- `chk_err` out 1: one-cycle pulse; checksum mismatch.
- `rx_busy` out 1: high while the byte receiver is not IDLE or the parser is not SYNC (LED drive).

## Operation
- `uart_rxd` passes through a 2-flop synchroniser (reset value 1) before any use.
- Byte receiver FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronised 1→0 transition moves to START and clears the bit counter.
  - START: sample at count `CLKS_PER_BIT/2`. If the line reads 1, the start was a glitch: return to IDLE, no error. Otherwise go to DATA and reset the counter.
  - DATA: sample every `CLKS_PER_BIT` cycles, LSB first, 8 bits.
  - STOP: sample once. A 1 pulses `byte_valid` with the byte. A 0 pulses `frame_err` and discards the byte. Either way return to IDLE immediately after the sample, so back-to-back start bits are caught.
- Packet parser FSM: SYNC → ADDR → DHI → DLO → CHK → SYNC. It advances only on `byte_valid`.
  - SYNC: a byte equal to `SYNC_BYTE` advances; any other byte is silently dropped.
  - CHK: expected value is `addr ^ dhi ^ dlo`. On a match, `cfg_addr`/`cfg_data` are loaded and `cfg_wr` pulses. On a mismatch, `chk_err` pulses and the outputs are unchanged.
- Error and abandon paths:
  - `frame_err` in any parser state forces the parser to SYNC.
  - Timeout: in any parser state other than SYNC, a counter counts cycles since the last `byte_valid`. At `TIMEOUT_BITS*CLKS_PER_BIT` the parser returns to SYNC without any error pulse. The counter clears on every `byte_valid`.
- A `SYNC_BYTE` value seen in ADDR, DHI, DLO or CHK is treated as data; there is no resynchronisation mid-packet.

## Timing
- Reset values: `cfg_wr`=0, `cfg_addr`=0, `cfg_data`=0, `frame_err`=0, `chk_err`=0, `rx_busy`=0. Both FSMs reset to IDLE/SYNC.
- Reset asserted mid-byte or mid-packet discards all partial state. No pulse is emitted on the reset cycle or the cycle after it.
- `byte_valid` is registered: it is high the cycle after the stop-bit sample.
- `cfg_wr`/`chk_err` are registered: they are high the cycle after the `byte_valid` for the CHK byte.
- Stop-bit sample to `cfg_wr` = 2 cycles.
- Start-edge detection latency is 2 cycles (synchroniser) + 1 cycle (edge register). The mid-bit sample point absorbs this.
- `cfg_wr`, `frame_err` and `chk_err` are mutually exclusive in any cycle.
- Receiver tolerance is ±2% baud mismatch.

## Structure
- Shared package `radiometer_pkg`:
  - `SYNC_BYTE` default.
  - Parser state enum.
  - Register address constants, e.g. `ADDR_SW_PERIOD`=8'h01, `ADDR_INT_LEN`=8'h02, `ADDR_UART_EN`=8'h03.
- Sub-module `uart_rx_byte`: synchroniser plus byte FSM.
  - Outputs `byte_valid`, `byte_data[7:0]`, `frame_err`, `busy`.
  - The parser, timeout counter and registers live in `uart_cmd_rx`.

## Test plan
Run all scenarios at `CLKS_PER_BIT`=16.

- Clean packet A5 01 12 34 27 → exactly one `cfg_wr`, with `cfg_addr`=8'h01 and `cfg_data`=16'h1234, 2 cycles after the last stop sample. `rx_busy` returns to 0.
- Bad checksum A5 02 00 FF 00 → one `chk_err`, no `cfg_wr`, and `cfg_addr`/`cfg_data` still hold the previous values. The next clean packet is then accepted.
- Garbage then packet 00 5A A5 03 00 01 02 → the leading bytes are ignored and `cfg_wr` fires with addr 03, data 0001.
- Stop bit driven low on the DHI byte → one `frame_err` and no `cfg_wr`. A following clean packet is accepted.
- Send A5 01, idle 21 bit times, then 12 34 27 → no `cfg_wr` and no error pulses. The parser is back in SYNC before the 12 byte arrives.
- Start-bit glitch of 3 cycles low → no `byte_valid` and no errors. Asserting `rst` mid-DATA then sending a clean packet gives exactly one correct `cfg_wr`.
